adxl362_controller: RTL and testbench
=====================================

ADXL362_CONTROLLER -- requirements
Module: adxl362_controller

Interface
REQ-001 Parameter CLK_FREQUENCY, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter SCLK_FREQUENCY, default 500_000, SPI clock frequency in Hz; passed to the SPI sub-module.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096, maximum clk cycles to wait on a single byte transfer (used only when the timeout feature is compiled in).
REQ-004 clk  input  1  system clock; all flops on posedge.
REQ-005 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-006 start  input  1  request one register access; sampled only in IDLE.
REQ-007 write  input  1  1 = register write, 0 = register read; latched on an accepted start.
REQ-008 addr  input  8  register address; latched on an accepted start.
REQ-009 wdata  input  8  write data; latched on an accepted start.
REQ-010 rdata  output  8  read data; updated only at the end of a read.
REQ-011 busy  output  1  high from the cycle after an accepted start until DONE.
REQ-012 done  output  1  one-cycle pulse when an access completes.
REQ-013 err  output  1  one-cycle pulse with done when an access aborts on timeout.
REQ-014 SPI_SCLK, SPI_MOSI, SPI_CS  output  1 each; SPI_MISO  input  1; SPI pins, mode 0.

Function
REQ-015 Each access SHALL be exactly three SPI bytes under one continuous CS-low window: command (0x0A write / 0x0B read), addr, then wdata (write) or 0x00 (read).
REQ-016 States SHALL be IDLE, SEND_CMD, WAIT_CMD, SEND_ADDR, WAIT_ADDR, SEND_DATA, WAIT_DATA, DONE.
REQ-017 Transitions: IDLE->SEND_CMD on start; each SEND_x->WAIT_x after 1 cycle; WAIT_CMD->SEND_ADDR, WAIT_ADDR->SEND_DATA, WAIT_DATA->DONE on the sub-module done; DONE->IDLE after 1 cycle.
REQ-018 SEND_x states SHALL drive a one-cycle spi start with the byte; hold_cs=1 for command and address, hold_cs=0 for data.
REQ-019 On a read, rdata SHALL load the byte received in the data phase on the WAIT_DATA->DONE edge; a write SHALL leave rdata unchanged.
REQ-020 done SHALL be high only in DONE; busy SHALL be high in every state except IDLE and DONE.
REQ-021 start in any state other than IDLE, including DONE, SHALL be ignored with no queuing.
REQ-022 write, addr and wdata SHALL be ignored after acceptance; changes mid-access SHALL have no effect.
REQ-023 Back-to-back: start held high SHALL begin the next access on the cycle after DONE, with CS high for at least one SCLK half-period between accesses.

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE, busy=0, done=0, err=0, rdata=0x00, SPI_CS=1, SPI_SCLK=0, SPI_MOSI=0, including mid-access.
REQ-025 The first access after rst_n deassertion SHALL be accepted no earlier than the second posedge clk.

Configuration
REQ-026 Macro ADXL362_TIMEOUT_EN defined: a counter SHALL clear on entry to each WAIT_x state; reaching TIMEOUT_CYCLES SHALL reset the sub-module, force CS high, go to DONE, pulse err with done, and leave rdata unchanged.
REQ-027 Macro ADXL362_TIMEOUT_EN undefined: no counter SHALL exist, WAIT_x SHALL wait indefinitely, and err SHALL be tied 0.

Structure
REQ-028 Package adxl362_pkg SHALL hold the state enum, CMD_WRITE=8'h0A, CMD_READ=8'h0B, and DUMMY_BYTE=8'h00.
REQ-029 The block SHALL instantiate one spi_controller sub-module, fed with the inverted rst_n (plus the timeout abort when enabled), as the only SPI pin driver.

Verification
REQ-030 Write addr=0x2D, wdata=0x02 -> MOSI bytes 0x0A,0x2D,0x02 with CS low throughout; one done pulse; rdata unchanged.
REQ-031 Read addr=0x00 with a slave model returning 0xAD -> MOSI bytes 0x0B,0x00,0x00; rdata=0xAD at done; busy low in the same cycle.
REQ-032 start re-pulsed during WAIT_ADDR, and addr changed to 0x55 mid-access -> a single access only, to the originally latched address.
REQ-033 rst_n pulsed low during the SEND_DATA/WAIT_DATA phase -> CS=1, SCLK=0, busy=0 immediately; the next read of 0x02 returns the model's 0xF2 correctly.
REQ-034 With ADXL362_TIMEOUT_EN and TIMEOUT_CYCLES=64, sub-module done withheld -> err and done high together 64 cycles after entering the WAIT state; CS=1; the following access succeeds.
REQ-035 start held high for two accesses -> both complete, with a CS-high gap of at least one SCLK half-period between them.

Source files
------------

// File: rtl/adxl362_pkg.sv
// Shared types and constants for the ADXL362 register-access controller.
package adxl362_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        WAIT_CMD,
        SEND_ADDR,
        WAIT_ADDR,
        SEND_DATA,
        WAIT_DATA,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        SPI_IDLE,
        SPI_XFER,
        SPI_GAP
    } spi_state_e;

    localparam logic [7:0] CMD_WRITE  = 8'h0A;
    localparam logic [7:0] CMD_READ   = 8'h0B;
    localparam logic [7:0] DUMMY_BYTE = 8'h00;

    // clk cycles per SCLK half-period, never below one
    function automatic int half_period_cycles(input int clk_hz, input int sclk_hz);
        int h;
        h = clk_hz / (2 * sclk_hz);
        return (h < 1) ? 1 : h;
    endfunction

endpackage

// File: rtl/adxl362_controller_spi.sv
// Mode-0 SPI byte engine: one byte per start, optional CS hold between bytes,
// and a CS-high guard of one SCLK half-period after the last byte of a frame.
module spi_controller
    import adxl362_pkg::*;
#(
    parameter int CLK_FREQUENCY  = 100_000_000,
    parameter int SCLK_FREQUENCY = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] tx_byte_i,
    input  logic       hold_cs_i,
    output logic       done_o,
    output logic [7:0] rx_byte_o,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic       cs_o,
    input  logic       miso_i
);

    localparam int HALF  = half_period_cycles(CLK_FREQUENCY, SCLK_FREQUENCY);
    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;

    spi_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       edge_q, edge_d;
    logic             sclk_q, sclk_d;
    logic             cs_q, cs_d;
    logic             mosi_q, mosi_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_q, rx_d;
    logic             hold_q, hold_d;
    logic             done_q, done_d;
    logic             half_tick;

    assign half_tick = (div_q == DIV_W'(HALF - 1));

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        edge_d  = edge_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        unique case (state_q)
            SPI_IDLE: begin
                if (start_i) begin
                    state_d = SPI_XFER;
                    cs_d    = 1'b0;
                    shift_d = tx_byte_i;
                    mosi_d  = tx_byte_i[7];
                    hold_d  = hold_cs_i;
                    div_d   = '0;
                    edge_d  = '0;
                end
            end
            SPI_XFER: begin
                div_d = half_tick ? '0 : div_q + 1'b1;
                if (half_tick) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 4'd1;
                    if (!sclk_q) begin
                        rx_d = {rx_q[6:0], miso_i};
                    end else begin
                        // falling edge: present the next bit, or close the byte
                        shift_d = {shift_q[6:0], 1'b0};
                        mosi_d  = shift_q[6];
                        if (edge_q == 4'd15) begin
                            mosi_d  = 1'b0;
                            done_d  = hold_q;
                            cs_d    = ~hold_q;
                            state_d = hold_q ? SPI_IDLE : SPI_GAP;
                        end
                    end
                end
            end
            SPI_GAP: begin
                div_d = half_tick ? '0 : div_q + 1'b1;
                if (half_tick) begin
                    done_d  = 1'b1;
                    state_d = SPI_IDLE;
                end
            end
            default: state_d = SPI_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SPI_IDLE;
            div_q   <= '0;
            edge_q  <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            shift_q <= '0;
            rx_q    <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            edge_q  <= edge_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    assign done_o    = done_q;
    assign rx_byte_o = rx_q;
    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign cs_o      = cs_q;

endmodule

// File: rtl/adxl362_controller.sv
// ADXL362 single-register read/write sequencer over a three-byte SPI frame.
// Optional per-byte watchdog: define ADXL362_TIMEOUT_EN.
module adxl362_controller
    import adxl362_pkg::*;
#(
    parameter int CLK_FREQUENCY  = 100_000_000,
    parameter int SCLK_FREQUENCY = 500_000,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       write,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       SPI_SCLK,
    output logic       SPI_MOSI,
    output logic       SPI_CS,
    input  logic       SPI_MISO
);

    if (TIMEOUT_CYCLES < 2 || 2 * SCLK_FREQUENCY > CLK_FREQUENCY) begin : g_param_check
        $error("adxl362_controller: invalid clock or timeout parameters");
    end

    state_e     state_q, state_d;
    logic       ready_q;
    logic       write_q;
    logic [7:0] addr_q, wdata_q, rdata_q;
    logic       accept;
    logic       spi_rst, spi_start, spi_hold, spi_done;
    logic [7:0] spi_tx, spi_rx;
    logic       timeout;

    // ready_q keeps the first posedge after reset release from accepting a start
    assign accept = (state_q == IDLE) && start && ready_q;

`ifdef ADXL362_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             abort_q, err_q, in_wait;

    assign in_wait = (state_q == WAIT_CMD) || (state_q == WAIT_ADDR) || (state_q == WAIT_DATA);
    assign timeout = in_wait && !spi_done && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            abort_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= in_wait ? tmo_cnt_q + 1'b1 : '0;
            abort_q   <= timeout;
            err_q     <= timeout;
        end
    end

    // abort_q is a flop output, so it is a clean reset source for the byte engine
    assign spi_rst = ~rst_n | abort_q;
    assign err     = err_q;
`else
    assign timeout = 1'b0;
    assign spi_rst = ~rst_n;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = DONE;
        end else begin
            unique case (state_q)
                IDLE:      if (accept) state_d = SEND_CMD;
                SEND_CMD:  state_d = WAIT_CMD;
                WAIT_CMD:  if (spi_done) state_d = SEND_ADDR;
                SEND_ADDR: state_d = WAIT_ADDR;
                WAIT_ADDR: if (spi_done) state_d = SEND_DATA;
                SEND_DATA: state_d = WAIT_DATA;
                WAIT_DATA: if (spi_done) state_d = DONE;
                DONE:      state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != IDLE) && (state_q != DONE);
        done      = (state_q == DONE);
        spi_start = 1'b0;
        spi_hold  = 1'b1;
        spi_tx    = DUMMY_BYTE;
        unique case (state_q)
            SEND_CMD: begin
                spi_start = 1'b1;
                spi_tx    = write_q ? CMD_WRITE : CMD_READ;
            end
            SEND_ADDR: begin
                spi_start = 1'b1;
                spi_tx    = addr_q;
            end
            SEND_DATA: begin
                spi_start = 1'b1;
                spi_hold  = 1'b0;
                spi_tx    = write_q ? wdata_q : DUMMY_BYTE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            ready_q <= 1'b1;
            if (accept) begin
                write_q <= write;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state_q == WAIT_DATA && spi_done && !write_q) begin
                rdata_q <= spi_rx;
            end
        end
    end

    assign rdata = rdata_q;

    spi_controller #(
        .CLK_FREQUENCY (CLK_FREQUENCY),
        .SCLK_FREQUENCY(SCLK_FREQUENCY)
    ) u_spi (
        .clk      (clk),
        .rst      (spi_rst),
        .start_i  (spi_start),
        .tx_byte_i(spi_tx),
        .hold_cs_i(spi_hold),
        .done_o   (spi_done),
        .rx_byte_o(spi_rx),
        .sclk_o   (SPI_SCLK),
        .mosi_o   (SPI_MOSI),
        .cs_o     (SPI_CS),
        .miso_i   (SPI_MISO)
    );

endmodule

// File: tb/tb_adxl362_controller.sv
// Bench for adxl362_controller: behavioural ADXL362 slave plus a register-file reference model.
module tb_adxl362_controller;

    localparam int CLK_HZ  = 100_000_000;
    localparam int SCLK_HZ = 10_000_000;
    localparam int HALF    = CLK_HZ / (2 * SCLK_HZ);
    localparam int BOUND   = 3000;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, write = 1'b0;
    logic [7:0] addr = 8'h00, wdata = 8'h00;
    logic [7:0] rdata;
    logic       busy, done, err, SPI_SCLK, SPI_MOSI, SPI_CS, SPI_MISO;

    always #5 clk = ~clk;

    adxl362_controller #(
        .CLK_FREQUENCY (CLK_HZ),
        .SCLK_FREQUENCY(SCLK_HZ),
        .TIMEOUT_CYCLES(4096)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .err(err),
        .SPI_SCLK(SPI_SCLK), .SPI_MOSI(SPI_MOSI), .SPI_CS(SPI_CS), .SPI_MISO(SPI_MISO)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [256];
    logic [7:0] ref_rdata;

    // behavioural slave
    logic [7:0] s_mem [256];
    logic [7:0] s_sh, s_cmd, s_addr, s_out;
    int         s_bit, s_byte;
    logic [7:0] mosi_log [$];
    int         n_win = 0, n_done = 0;
    time        t_rise = 0, min_gap = 0;

    always @(posedge SPI_CS) t_rise = $time;

    always @(negedge SPI_CS) begin
        s_bit  = 0;
        s_byte = 0;
        n_win++;
        if (($time - t_rise) < min_gap) min_gap = $time - t_rise;
    end

    always @(posedge SPI_SCLK) begin
        if (SPI_CS === 1'b0) begin
            s_sh = {s_sh[6:0], SPI_MOSI};
            s_bit++;
            if (s_bit == 8) begin
                s_bit = 0;
                mosi_log.push_back(s_sh);
                if (s_byte == 0) s_cmd = s_sh;
                else if (s_byte == 1) begin
                    s_addr = s_sh;
                    s_out  = s_mem[s_sh];
                end else if (s_byte == 2 && s_cmd == 8'h0A) s_mem[s_addr] = s_sh;
                s_byte++;
            end
        end
    end

    always_comb begin
        SPI_MISO = 1'b0;
        if (SPI_CS === 1'b0 && s_byte == 2 && s_cmd == 8'h0B && s_bit < 8)
            SPI_MISO = s_out[3'(7 - s_bit)];
    end

    always @(negedge clk) if (done === 1'b1) n_done++;

    typedef struct {
        bit          ok;
        int          nbytes;
        logic [23:0] bytes;
        int          wins;
        logic        busy_at;
        logic        err_at;
        logic        done_next;
        logic [7:0]  rdata;
    } obs_t;

    function automatic logic [23:0] exp_frame(input logic w, input logic [7:0] a, input logic [7:0] d);
        return {(w ? 8'h0A : 8'h0B), a, (w ? d : 8'h00)};
    endfunction

    // Drives one access, scrambles the inputs after acceptance, and collects observations.
    task automatic run_access(input logic w, input logic [7:0] a, input logic [7:0] d, output obs_t o);
        int w0;
        o.ok = 0; o.nbytes = 0; o.bytes = '0; o.busy_at = 1'bx; o.err_at = 1'bx; o.rdata = 8'hxx;
        mosi_log.delete();
        w0 = n_win;
        @(negedge clk);
        write = w; addr = a; wdata = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0; write = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
        for (int i = 0; i < BOUND && !o.ok; i++) begin
            if (done === 1'b1) begin
                o.ok = 1; o.busy_at = busy; o.err_at = err; o.rdata = rdata;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        o.done_next = done;
        o.wins      = n_win - w0;
        o.nbytes    = mosi_log.size();
        for (int i = 0; i < o.nbytes && i < 3; i++) o.bytes[23 - 8*i -: 8] = mosi_log[i];
    endtask

    task automatic test_reset();
        bit seen;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0)    begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        checks++; if (SPI_CS !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b want 1", SPI_CS); end
        checks++; if (SPI_SCLK !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", SPI_SCLK); end
        checks++; if (SPI_MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", SPI_MOSI); end
        // start already high when reset releases: first posedge must not accept it
        mosi_log.delete();
        write = 1'b0; addr = 8'h00; start = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_first_edge: busy %b want 0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_second_edge: busy %b want 1", busy); end
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < BOUND && !seen; i++) begin
            if (done === 1'b1) seen = 1; else @(negedge clk);
        end
        ref_rdata = ref_mem[8'h00];
        checks++; if (!seen || rdata !== ref_rdata) begin errors++; $display("FAIL reset_first_read: done=%0d rdata %h want %h", seen, rdata, ref_rdata); end
        $display("reset: first access read addr 00 -> %h", rdata);
        @(negedge clk);
    endtask

    task automatic test_write();
        obs_t o;
        run_access(1'b1, 8'h2D, 8'h02, o);
        ref_mem[8'h2D] = 8'h02;
        checks++; if (!o.ok) begin errors++; $display("FAIL write_done: no done within %0d cycles", BOUND); end
        checks++; if (o.nbytes != 3 || o.bytes !== exp_frame(1'b1, 8'h2D, 8'h02))
            begin errors++; $display("FAIL write_bytes: got %0d bytes %h want 0a2d02", o.nbytes, o.bytes); end
        checks++; if (o.wins != 1) begin errors++; $display("FAIL write_cs_window: got %0d want 1", o.wins); end
        checks++; if (o.rdata !== ref_rdata) begin errors++; $display("FAIL write_rdata: got %h want %h", o.rdata, ref_rdata); end
        checks++; if (o.done_next !== 1'b0) begin errors++; $display("FAIL write_done_pulse: done still %b", o.done_next); end
        $display("write addr 2d data 02: bytes %h windows %0d rdata %h", o.bytes, o.wins, o.rdata);
    endtask

    task automatic test_read();
        obs_t o;
        run_access(1'b0, 8'h00, 8'h00, o);
        ref_rdata = ref_mem[8'h00];
        checks++; if (!o.ok) begin errors++; $display("FAIL read_done: no done within %0d cycles", BOUND); end
        checks++; if (o.nbytes != 3 || o.bytes !== exp_frame(1'b0, 8'h00, 8'h00))
            begin errors++; $display("FAIL read_bytes: got %0d bytes %h want 0b0000", o.nbytes, o.bytes); end
        checks++; if (o.rdata !== 8'hAD) begin errors++; $display("FAIL read_rdata: got %h want ad", o.rdata); end
        checks++; if (o.busy_at !== 1'b0) begin errors++; $display("FAIL read_busy_at_done: got %b want 0", o.busy_at); end
        checks++; if (o.err_at !== 1'b0) begin errors++; $display("FAIL read_err_at_done: got %b want 0", o.err_at); end
        $display("read addr 00: bytes %h rdata %h", o.bytes, o.rdata);
    endtask

    task automatic test_random();
        obs_t o;
        logic w;
        logic [7:0] a, d;
        for (int n = 0; n < 10; n++) begin
            w = 1'($urandom);
            a = 8'($urandom_range(8'h10, 8'hFF));
            d = 8'($urandom);
            run_access(w, a, d, o);
            if (w) ref_mem[a] = d; else ref_rdata = ref_mem[a];
            checks++; if (!o.ok) begin errors++; $display("FAIL rand_done[%0d]: no done", n); end
            checks++; if (o.nbytes != 3 || o.bytes !== exp_frame(w, a, d))
                begin errors++; $display("FAIL rand_bytes[%0d]: got %h want %h", n, o.bytes, exp_frame(w, a, d)); end
            checks++; if (o.wins != 1) begin errors++; $display("FAIL rand_cs_window[%0d]: got %0d want 1", n, o.wins); end
            checks++; if (o.rdata !== ref_rdata) begin errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", n, o.rdata, ref_rdata); end
            checks++; if (o.busy_at !== 1'b0 || o.done_next !== 1'b0)
                begin errors++; $display("FAIL rand_handshake[%0d]: busy_at %b done_next %b want 0 0", n, o.busy_at, o.done_next); end
            $display("rand %0d: %s addr %h data %h bytes %h rdata %h", n, w ? "write" : "read ", a, d, o.bytes, o.rdata);
        end
    endtask

    task automatic test_ignore_restart();
        logic [7:0] a;
        int w0, d0;
        bit seen;
        a = 8'($urandom_range(8'h10, 8'h50));
        mosi_log.delete();
        w0 = n_win; d0 = n_done;
        @(negedge clk); write = 1'b0; addr = a; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < BOUND && mosi_log.size() < 1; i++) @(negedge clk);
        repeat (2 * HALF) @(negedge clk);
        // now in the address byte: re-pulse start with a different request
        write = 1'b1; addr = 8'h55; wdata = 8'hEE; start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 0;
        for (int i = 0; i < BOUND && !seen; i++) begin
            if (done === 1'b1) seen = 1; else @(negedge clk);
        end
        ref_rdata = ref_mem[a];
        checks++; if (!seen || rdata !== ref_rdata) begin errors++; $display("FAIL ignore_rdata: done=%0d got %h want %h", seen, rdata, ref_rdata); end
        checks++; if (mosi_log.size() != 3 || mosi_log[0] !== 8'h0B || mosi_log[1] !== a || mosi_log[2] !== 8'h00)
            begin errors++; $display("FAIL ignore_bytes: got %0d bytes want 0b %h 00", mosi_log.size(), a); end
        repeat (400) @(negedge clk);
        checks++; if (n_win - w0 != 1 || n_done - d0 != 1)
            begin errors++; $display("FAIL ignore_single_access: windows %0d dones %0d want 1 1", n_win - w0, n_done - d0); end
        checks++; if (s_mem[8'h55] !== ref_mem[8'h55]) begin errors++; $display("FAIL ignore_no_write: mem[55] %h want %h", s_mem[8'h55], ref_mem[8'h55]); end
        $display("ignore: addr %h read %h, windows %0d", a, rdata, n_win - w0);
    endtask

    task automatic test_reset_mid();
        obs_t o;
        mosi_log.delete();
        @(negedge clk); write = 1'b0; addr = 8'h20; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < BOUND && mosi_log.size() < 2; i++) @(negedge clk);
        repeat (3 * HALF) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (SPI_CS !== 1'b1 || SPI_SCLK !== 1'b0 || SPI_MOSI !== 1'b0)
            begin errors++; $display("FAIL midreset_pins: cs %b sclk %b mosi %b want 1 0 0", SPI_CS, SPI_SCLK, SPI_MOSI); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_status: busy %b done %b want 0 0", busy, done); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL midreset_rdata: got %h want 00", rdata); end
        ref_rdata = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_access(1'b0, 8'h02, 8'h00, o);
        ref_rdata = ref_mem[8'h02];
        checks++; if (!o.ok || o.rdata !== 8'hF2) begin errors++; $display("FAIL midreset_next_read: done=%0d got %h want f2", o.ok, o.rdata); end
        checks++; if (o.bytes !== exp_frame(1'b0, 8'h02, 8'h00)) begin errors++; $display("FAIL midreset_bytes: got %h want 0b0200", o.bytes); end
        $display("mid-access reset, then read addr 02 -> %h", o.rdata);
    endtask

    task automatic test_back_to_back();
        int w0, seen;
        mosi_log.delete();
        w0 = n_win;
        min_gap = 64'd1_000_000_000;
        seen = 0;
        @(negedge clk); write = 1'b0; addr = 8'h01; start = 1'b1;
        for (int i = 0; i < 2 * BOUND && seen < 2; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        start = 1'b0;
        repeat (400) @(negedge clk);
        ref_rdata = ref_mem[8'h01];
        checks++; if (seen != 2) begin errors++; $display("FAIL b2b_dones: got %0d want 2", seen); end
        checks++; if (n_win - w0 != 2) begin errors++; $display("FAIL b2b_windows: got %0d want 2", n_win - w0); end
        checks++; if (min_gap < HALF * 10) begin errors++; $display("FAIL b2b_cs_gap: got %0t want >= %0d ns", min_gap, HALF * 10); end
        checks++; if (mosi_log.size() != 6 || mosi_log[3] !== 8'h0B || mosi_log[4] !== 8'h01)
            begin errors++; $display("FAIL b2b_bytes: got %0d bytes want 6", mosi_log.size()); end
        checks++; if (rdata !== ref_rdata) begin errors++; $display("FAIL b2b_rdata: got %h want %h", rdata, ref_rdata); end
        $display("back-to-back: dones %0d windows %0d min cs gap %0t", seen, n_win - w0, min_gap);
    endtask

`ifdef ADXL362_TIMEOUT_EN
    // This instance's SPI byte takes longer than its watchdog, so WAIT_CMD always expires.
    logic       t_start = 1'b0;
    logic [7:0] t_rdata;
    logic       t_busy, t_done, t_err, t_sclk, t_mosi, t_cs;

    adxl362_controller #(
        .CLK_FREQUENCY (CLK_HZ),
        .SCLK_FREQUENCY(SCLK_HZ),
        .TIMEOUT_CYCLES(64)
    ) dut_tmo (
        .clk(clk), .rst_n(rst_n), .start(t_start), .write(1'b0), .addr(8'h00), .wdata(8'h00),
        .rdata(t_rdata), .busy(t_busy), .done(t_done), .err(t_err),
        .SPI_SCLK(t_sclk), .SPI_MOSI(t_mosi), .SPI_CS(t_cs), .SPI_MISO(1'b0)
    );

    task automatic test_timeout();
        int k;
        k = 0;
        @(negedge clk); t_start = 1'b1;
        @(negedge clk); t_start = 1'b0;
        for (int i = 2; i < 400 && k == 0; i++) begin
            @(negedge clk);
            if (t_done === 1'b1) k = i;
        end
        // accept, SEND_CMD, then 64 cycles in WAIT_CMD
        checks++; if (k != 66) begin errors++; $display("FAIL timeout_latency: done at %0d want 66", k); end
        checks++; if (t_err !== 1'b1 || t_cs !== 1'b1 || t_rdata !== 8'h00)
            begin errors++; $display("FAIL timeout_outputs: err %b cs %b rdata %h want 1 1 00", t_err, t_cs, t_rdata); end
        $display("timeout: done+err after %0d cycles", k);
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'(i * 7 + 3);
        end
        ref_mem[8'h00] = 8'hAD;
        ref_mem[8'h01] = 8'h1D;
        ref_mem[8'h02] = 8'hF2;
        for (int i = 0; i < 256; i++) s_mem[i] = ref_mem[i];
        ref_rdata = 8'h00;
        s_bit = 0; s_byte = 0; s_cmd = 8'h00; s_sh = 8'h00; s_out = 8'h00; s_addr = 8'h00;

        test_reset();
        test_write();
        test_read();
        test_random();
        test_ignore_restart();
        test_reset_mid();
        test_back_to_back();
`ifdef ADXL362_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
